phase_timer: RTL and testbench

//  Phase-duration timer and sequencing controller for the intersection traffic-light FSM.
//  - Takes the per-phase duration (seconds) from the FSM and prescales the 10 kHz system clock to 1 s ticks.
//  - Counts the phase down and raises `finished` so the FSM advances to its next state.
//  - Supports sensor-driven early termination with a guaranteed minimum remaining time.

---
 rtl/phase_timer_if.sv | 22 ++
 rtl/phase_timer.sv | 98 +++++++++
 tb/tb_phase_timer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/phase_timer_if.sv
// Control/status bundle between the traffic-light FSM (master) and phase_timer (slave).
interface phase_timer_if #(
    parameter int SEC_W = 16
);
    logic             enable_general;
    logic             load;
    logic [SEC_W-1:0] seconds_to_count;
    logic             abort;
    logic             finished;
    logic [SEC_W-1:0] secs_left;
    logic             tick_1hz;

    modport master (
        output enable_general, load, seconds_to_count, abort,
        input  finished, secs_left, tick_1hz
    );

    modport slave (
        input  enable_general, load, seconds_to_count, abort,
        output finished, secs_left, tick_1hz
    );
endinterface

// File: rtl/phase_timer.sv
// Phase-duration timer: prescales clk to 1 s ticks, counts a phase down, supports early abort.
// Build option FAST_SIM_EN: one "second" lasts 10 clk cycles regardless of CLK_HZ.
module phase_timer #(
    parameter int CLK_HZ     = 10000,
    parameter int SEC_W      = 16,
    parameter int MIN_REMAIN = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    phase_timer_if.slave  bus
);

`ifdef FAST_SIM_EN
    localparam int PRE_W = ($clog2(CLK_HZ) > 4) ? $clog2(CLK_HZ) : 4;
    localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(9);
`else
    localparam int PRE_W = ($clog2(CLK_HZ) < 1) ? 1 : $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(CLK_HZ - 1);
`endif

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DONE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic [SEC_W-1:0] secs_left_q;
    logic             finished_q;
    logic             tick_q;

    // Priority inside one edge: disable > load > abort > tick decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_OFF;
            prescaler   <= '0;
            secs_left_q <= '0;
            finished_q  <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (!bus.enable_general) begin
                state       <= ST_OFF;
                prescaler   <= '0;
                secs_left_q <= '0;
                finished_q  <= 1'b1;
            end else begin
                case (state)
                    ST_OFF: begin
                        state <= ST_DONE;
                    end
                    ST_DONE, ST_RUN: begin
                        if (bus.load) begin
                            prescaler <= '0;
                            if (bus.seconds_to_count != '0) begin
                                state       <= ST_RUN;
                                secs_left_q <= bus.seconds_to_count;
                                finished_q  <= 1'b0;
                            end else begin
                                state       <= ST_DONE;
                                secs_left_q <= '0;
                                finished_q  <= 1'b1;
                            end
                        end else if (state == ST_RUN) begin
                            // An abort only ever shortens the phase, never lengthens it.
                            if (bus.abort && (secs_left_q > SEC_W'(MIN_REMAIN))) begin
                                secs_left_q <= SEC_W'(MIN_REMAIN);
                                prescaler   <= '0;
                            end else if (prescaler == TERMINAL) begin
                                prescaler   <= '0;
                                tick_q      <= 1'b1;
                                secs_left_q <= secs_left_q - SEC_W'(1);
                                if (secs_left_q == SEC_W'(1)) begin
                                    state      <= ST_DONE;
                                    finished_q <= 1'b1;
                                end
                            end else begin
                                prescaler <= prescaler + PRE_W'(1);
                            end
                        end
                    end
                    default: begin
                        state       <= ST_OFF;
                        prescaler   <= '0;
                        secs_left_q <= '0;
                        finished_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.finished  = finished_q;
    assign bus.secs_left = secs_left_q;
    assign bus.tick_1hz  = tick_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: directed scenarios plus random traffic against a deadline-based model.
module tb_phase_timer;
    localparam int CLK_HZ     = 10;
    localparam int SEC_W      = 16;
    localparam int MIN_REMAIN = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    phase_timer_if #(.SEC_W(SEC_W)) bus ();

    phase_timer #(
        .CLK_HZ(CLK_HZ),
        .SEC_W(SEC_W),
        .MIN_REMAIN(MIN_REMAIN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: a running phase is just an absolute deadline cycle; seconds left is the ceiling of time to go.
    typedef enum int {M_OFF, M_IDLE, M_RUN} mode_t;
    mode_t mode = M_OFF;
    int    cyc = 0;
    int    deadline = 0;
    int    exp_secs = 0;
    logic  exp_fin = 1'b1;
    logic  exp_tick = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("finished", {31'd0, bus.finished}, {31'd0, exp_fin});
        check("secs_left", {16'd0, bus.secs_left}, exp_secs);
        check("tick_1hz", {31'd0, bus.tick_1hz}, {31'd0, exp_tick});
    endtask

    task automatic model_edge(input logic en, input logic ld, input int n, input logic ab);
        logic was_run;
        was_run  = (mode == M_RUN);
        exp_tick = 1'b0;
        if (!en) begin
            mode = M_OFF;
        end else if (mode == M_OFF) begin
            mode = M_IDLE;
        end else if (ld) begin
            if (n > 0) begin
                mode     = M_RUN;
                deadline = cyc + n * CLK_HZ;
            end else begin
                mode = M_IDLE;
            end
        end else if (was_run && ab && exp_secs > MIN_REMAIN) begin
            deadline = cyc + MIN_REMAIN * CLK_HZ;
        end else if (was_run) begin
            if ((deadline - cyc) % CLK_HZ == 0) exp_tick = 1'b1;
            if (cyc >= deadline) mode = M_IDLE;
        end
        exp_fin  = (mode != M_RUN);
        exp_secs = (mode == M_RUN) ? (deadline - cyc + CLK_HZ - 1) / CLK_HZ : 0;
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input int n, input logic ab);
        @(negedge clk);
        bus.enable_general   = en;
        bus.load             = ld;
        bus.seconds_to_count = SEC_W'(n);
        bus.abort            = ab;
        @(posedge clk);
        cyc++;
        model_edge(en, ld, n, ab);
        #1;
        check_all();
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic run_until_secs(input string tag, input int target);
        for (int k = 0; k < 500 && exp_secs != target; k++) idle(1);
        check(tag, {16'd0, bus.secs_left}, target);
    endtask

    initial begin
        int load_cyc;
        bus.enable_general   = 1'b0;
        bus.load             = 1'b0;
        bus.seconds_to_count = '0;
        bus.abort            = 1'b0;

        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Scenario 1: N=5, finished exactly 50 cycles after the load edge.
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        check("t1_secs_after_load", {16'd0, bus.secs_left}, 5);
        idle(49);
        check("t1_finished_at_49", {31'd0, bus.finished}, 0);
        idle(1);
        check("t1_finished_at_50", {31'd0, bus.finished}, 1);
        check("t1_tick_at_50", {31'd0, bus.tick_1hz}, 1);

        // Scenario 2: zero-length load is a no-op.
        applyStimulus(1'b1, 1'b1, 0, 1'b0);
        check("t2_finished", {31'd0, bus.finished}, 1);
        idle(12);

        // Scenario 3: abort at 15 s cuts the phase to 3 s.
        applyStimulus(1'b1, 1'b1, 20, 1'b0);
        run_until_secs("t3_reach15", 15);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        check("t3_secs_after_abort", {16'd0, bus.secs_left}, 3);
        idle(29);
        check("t3_finished_29", {31'd0, bus.finished}, 0);
        idle(1);
        check("t3_finished_30", {31'd0, bus.finished}, 1);

        // Scenario 4: abort at 2 s has no effect.
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        load_cyc = cyc;
        run_until_secs("t4_reach2", 2);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        check("t4_secs_unchanged", {16'd0, bus.secs_left}, 2);
        for (int k = 0; k < 100 && !bus.finished; k++) idle(1);
        check("t4_phase_length", cyc - load_cyc, 50);

        // Scenario 5: disable mid-phase, then re-enable and run a short phase.
        applyStimulus(1'b1, 1'b1, 8, 1'b0);
        run_until_secs("t5_reach4", 4);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        check("t5_off_finished", {31'd0, bus.finished}, 1);
        check("t5_off_secs", {16'd0, bus.secs_left}, 0);
        applyStimulus(1'b0, 1'b1, 6, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2, 1'b0);
        idle(19);
        check("t5_finished_19", {31'd0, bus.finished}, 0);
        idle(1);
        check("t5_finished_20", {31'd0, bus.finished}, 1);

        // Scenario 6: load beats abort, then async reset mid-phase.
        applyStimulus(1'b1, 1'b1, 10, 1'b1);
        check("t6_load_wins", {16'd0, bus.secs_left}, 10);
        idle(17);
        #1;
        reset_n = 1'b0;
        #1;
        mode = M_OFF; exp_fin = 1'b1; exp_secs = 0; exp_tick = 1'b0;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic: mostly enabled, occasional loads, aborts and disables.
        for (int i = 0; i < 3000; i++) begin
            logic en, ld, ab;
            int   n;
            en = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 99) < 4);
            ab = ($urandom_range(0, 99) < 3);
            n  = $urandom_range(0, 7);
            applyStimulus(en, ld, n, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
